// File: rtl/sfx_sequencer.sv
// Single-channel sound-effect sequencer: priority-arbitrated jump/score/death
// triggers step through a fixed note table and drive one codec channel.
module sfx_sequencer #(
  parameter int TICK_DIV = 184320
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [2:0]  iTrig,
  input  logic        iMute,
  output logic        oEnable,
  output logic [15:0] oFreq,
  output logic        oBusy,
  output logic [1:0]  oEffect,
  output logic        oDone
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [1:0] EFF_IDLE = 2'd3;

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  function automatic logic [15:0] note_freq(input logic [1:0] eff, input logic [1:0] step);
    case ({eff, step})
      4'b00_00: note_freq = 16'd880;
      4'b00_01: note_freq = 16'd1320;
      4'b01_00: note_freq = 16'd1568;
      4'b01_01: note_freq = 16'd2093;
      4'b10_00: note_freq = 16'd440;
      4'b10_01: note_freq = 16'd330;
      4'b10_10: note_freq = 16'd220;
      4'b10_11: note_freq = 16'd165;
      default:  note_freq = 16'd0;
    endcase
  endfunction

  function automatic logic [7:0] note_dur(input logic [1:0] eff, input logic [1:0] step);
    case ({eff, step})
      4'b00_00: note_dur = 8'd3;
      4'b00_01: note_dur = 8'd3;
      4'b01_00: note_dur = 8'd4;
      4'b01_01: note_dur = 8'd8;
      4'b10_00: note_dur = 8'd6;
      4'b10_01: note_dur = 8'd6;
      4'b10_10: note_dur = 8'd6;
      4'b10_11: note_dur = 8'd12;
      default:  note_dur = 8'd0;
    endcase
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] eff);
    last_step = (eff == 2'd2) ? 2'd3 : 2'd1;
  endfunction

  state_t         state_q, state_n;
  logic [1:0]     eff_q, eff_n;
  logic [1:0]     step_q, step_n;
  logic [7:0]     rem_q, rem_n;
  logic [PW-1:0]  ps_q, ps_n;
  logic [15:0]    freq_p0, freq_n;
  logic           done_p0, done_n;
  logic           trig_any;
  logic [1:0]     win;
  logic           tick;

  assign trig_any = |iTrig;
  assign win      = iTrig[2] ? 2'd2 : (iTrig[1] ? 2'd1 : 2'd0);
  assign tick     = (ps_q == PS_LAST);

  always_comb begin
    state_n = state_q;
    eff_n   = eff_q;
    step_n  = step_q;
    rem_n   = rem_q;
    ps_n    = ps_q;
    done_n  = 1'b0;
    // A trigger (fresh or preempting) always outranks a tick in the same cycle.
    if (trig_any && (state_q == S_IDLE || win >= eff_q)) begin
      state_n = S_PLAY;
      eff_n   = win;
      step_n  = 2'd0;
      rem_n   = note_dur(win, 2'd0);
      ps_n    = '0;
    end else if (state_q == S_PLAY) begin
      if (!tick) begin
        ps_n = ps_q + PW'(1);
      end else begin
        ps_n = '0;
        if (rem_q != 8'd1) begin
          rem_n = rem_q - 8'd1;
        end else if (step_q != last_step(eff_q)) begin
          step_n = step_q + 2'd1;
          rem_n  = note_dur(eff_q, step_q + 2'd1);
        end else begin
          state_n = S_IDLE;
          eff_n   = EFF_IDLE;
          step_n  = 2'd0;
          rem_n   = 8'd0;
          done_n  = 1'b1;
        end
      end
    end
    freq_n = (state_n == S_PLAY) ? note_freq(eff_n, step_n) : 16'd0;
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= S_IDLE;
      eff_q   <= EFF_IDLE;
      step_q  <= 2'd0;
      rem_q   <= 8'd0;
      ps_q    <= '0;
      freq_p0 <= 16'd0;
      done_p0 <= 1'b0;
    end else begin
      state_q <= state_n;
      eff_q   <= eff_n;
      step_q  <= step_n;
      rem_q   <= rem_n;
      ps_q    <= ps_n;
      freq_p0 <= freq_n;
      done_p0 <= done_n;
    end
  end

  // Mute gates the enable combinationally so it takes effect without a cycle of lag.
  assign oBusy   = (state_q == S_PLAY);
  assign oEnable = oBusy & ~iMute;
  assign oFreq   = freq_p0;
  assign oEffect = eff_q;
  assign oDone   = done_p0;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed scoreboard bench for sfx_sequencer with TICK_DIV = 4.
module tb_sfx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iTrig;
  logic        iMute;
  logic        oEnable;
  logic [15:0] oFreq;
  logic        oBusy;
  logic [1:0]  oEffect;
  logic        oDone;

  sfx_sequencer #(.TICK_DIV(4)) dut (
    .iClock (clk),
    .iReset (rst),
    .iTrig  (iTrig),
    .iMute  (iMute),
    .oEnable(oEnable),
    .oFreq  (oFreq),
    .oBusy  (oBusy),
    .oEffect(oEffect),
    .oDone  (oDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] f;
    logic        en;
    logic        busy;
    logic [1:0]  eff;
    logic        done;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] tsched[0:255];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic push(input int n, input logic [15:0] f, input logic en,
                      input logic [1:0] eff, input logic done);
    exp_t e;
    e.f = f; e.en = en; e.busy = (eff != 2'd3); e.eff = eff; e.done = done;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic idle(input int n);
    push(n, 16'd0, 1'b0, 2'd3, 1'b0);
  endtask

  task automatic done_pulse();
    push(1, 16'd0, 1'b0, 2'd3, 1'b1);
  endtask

  task automatic check_pop(input string tag, input int c);
    exp_t e;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s sb_empty cyc %0d: got size %0d exp >0", tag, c, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      vectors += 5;
      assert (oFreq === e.f) else begin
        miscompares++;
        $error("FAIL %s freq cyc %0d: got %0d exp %0d", tag, c, oFreq, e.f);
      end
      assert (oEnable === e.en) else begin
        miscompares++;
        $error("FAIL %s enable cyc %0d: got %b exp %b", tag, c, oEnable, e.en);
      end
      assert (oBusy === e.busy) else begin
        miscompares++;
        $error("FAIL %s busy cyc %0d: got %b exp %b", tag, c, oBusy, e.busy);
      end
      assert (oEffect === e.eff) else begin
        miscompares++;
        $error("FAIL %s effect cyc %0d: got %0d exp %0d", tag, c, oEffect, e.eff);
      end
      assert (oDone === e.done) else begin
        miscompares++;
        $error("FAIL %s done cyc %0d: got %b exp %b", tag, c, oDone, e.done);
      end
    end
  endtask

  task automatic clr_sched();
    for (int i = 0; i < 256; i++) tsched[i] = 3'b000;
  endtask

  task automatic run_scn(input string tag, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check_pop(tag, c);
      iTrig = tsched[c];
    end
    iTrig = 3'b000;
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL %s sb_leftover: got %0d exp 0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic scn_jump(input string tag);
    clr_sched();
    tsched[0] = 3'b001;
    idle(1);
    push(12, 16'd880, 1'b1, 2'd0, 1'b0);
    push(12, 16'd1320, 1'b1, 2'd0, 1'b0);
    done_pulse();
    idle(1);
    run_scn(tag, 27);
  endtask

  initial begin
    rst   = 1'b1;
    iTrig = 3'b000;
    iMute = 1'b0;
    clr_sched();
    repeat (2) @(negedge clk);
    idle(1);
    check_pop("reset", 0);
    sb.delete();
    rst = 1'b0;

    scn_jump("jump");

    // Simultaneous triggers: death wins.
    clr_sched();
    tsched[0] = 3'b111;
    idle(1);
    push(24, 16'd440, 1'b1, 2'd2, 1'b0);
    push(24, 16'd330, 1'b1, 2'd2, 1'b0);
    push(24, 16'd220, 1'b1, 2'd2, 1'b0);
    push(48, 16'd165, 1'b1, 2'd2, 1'b0);
    done_pulse();
    idle(1);
    run_scn("simul", 123);

    // Preemption by death, then a lower-priority jump is dropped.
    clr_sched();
    tsched[0] = 3'b010; tsched[10] = 3'b100; tsched[20] = 3'b001;
    idle(1);
    push(10, 16'd1568, 1'b1, 2'd1, 1'b0);
    push(24, 16'd440, 1'b1, 2'd2, 1'b0);
    push(24, 16'd330, 1'b1, 2'd2, 1'b0);
    push(24, 16'd220, 1'b1, 2'd2, 1'b0);
    push(48, 16'd165, 1'b1, 2'd2, 1'b0);
    done_pulse();
    idle(1);
    run_scn("preempt", 133);

    // Equal-priority restart.
    clr_sched();
    tsched[0] = 3'b001; tsched[8] = 3'b001;
    idle(1);
    push(20, 16'd880, 1'b1, 2'd0, 1'b0);
    push(12, 16'd1320, 1'b1, 2'd0, 1'b0);
    done_pulse();
    idle(1);
    run_scn("restart", 35);

    // Mute during score.
    iMute = 1'b1;
    clr_sched();
    tsched[0] = 3'b010;
    idle(1);
    push(16, 16'd1568, 1'b0, 2'd1, 1'b0);
    push(32, 16'd2093, 1'b0, 2'd1, 1'b0);
    done_pulse();
    idle(1);
    run_scn("mute", 51);
    iMute = 1'b0;

    // Trigger coinciding with the final tick restarts without a done pulse.
    clr_sched();
    tsched[0] = 3'b001; tsched[24] = 3'b001;
    idle(1);
    push(12, 16'd880, 1'b1, 2'd0, 1'b0);
    push(12, 16'd1320, 1'b1, 2'd0, 1'b0);
    push(12, 16'd880, 1'b1, 2'd0, 1'b0);
    push(12, 16'd1320, 1'b1, 2'd0, 1'b0);
    done_pulse();
    idle(1);
    run_scn("lasttick", 51);

    // Reset mid-death: outputs clear asynchronously, then stay quiet.
    clr_sched();
    tsched[0] = 3'b100;
    idle(1);
    push(24, 16'd440, 1'b1, 2'd2, 1'b0);
    push(6, 16'd330, 1'b1, 2'd2, 1'b0);
    run_scn("rst_pre", 31);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    idle(1);
    check_pop("rst_async", 30);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr_sched();
    idle(10);
    run_scn("rst_quiet", 10);

    scn_jump("jump_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Single-channel sound-effect sequencer between the game-register write path and the audio codec. It takes one-cycle trigger pulses for the jump, score and death effects, arbitrates them by priority, and steps through a fixed note table for the selected effect. It drives a channel enable and a 16-bit frequency word straight into one `adio_codec` channel. The block replaces the three separate per-effect generators, freeing codec channels 2–4.

## Interface

Parameters:
- `TICK_DIV`, default 184320: `iClock` cycles per sequencer tick (10 ms at 18.432 MHz). Legal range ≥ 2.

Ports:
- `iClock`, in, 1: sole clock, the audio control clock; all logic is on the rising edge.
- `iReset`, in, 1: asynchronous, active-high reset.
- `iTrig`, in, 3: one-cycle request pulses, synchronous to `iClock`. Bit 0 = jump, bit 1 = score, bit 2 = death.
- `iMute`, in, 1: forces `oEnable` low while sequencing continues.
- `oEnable`, out, 1: channel enable to the codec.
- `oFreq`, out, 16: tone frequency in Hz to the codec.
- `oBusy`, out, 1: high while an effect is playing.
- `oEffect`, out, 2: id of the effect playing (0 jump, 1 score, 2 death); 3 when idle.
- `oDone`, out, 1: one-cycle pulse when an effect completes naturally.

## Operation

Note table, fixed (frequency in Hz / duration in ticks):
- jump: 880/3, 1320/3
- score: 1568/4, 2093/8
- death: 440/6, 330/6, 220/6, 165/12

State:
- state ∈ {IDLE, PLAY}
- effect id, 2 bits
- step index, 2 bits
- tick-remaining counter, 8 bits
- prescaler, `$clog2(TICK_DIV)` bits

Arbitration and triggering:
- Priority is death > score > jump. When several `iTrig` bits are set in the same cycle, the highest wins and the others are discarded.
- IDLE: on any `iTrig` bit, latch the winning effect, set step = 0, load remaining = dur0, clear the prescaler, and go to PLAY.
- PLAY, preemption: a trigger whose priority is ≥ the current effect's restarts from step 0 of the new effect, with the same loads as above. `oDone` does not pulse on preemption. A lower-priority trigger is dropped, not queued.

Sequencing in PLAY:
- The prescaler counts 0 … `TICK_DIV`−1 and wraps. A tick occurs in the cycle where prescaler == `TICK_DIV`−1.
- On a tick, remaining decrements. When remaining would reach 0:
  - If the step is not the last, advance the step and load the next duration.
  - If it is the last step, go to IDLE and pulse `oDone`.
- A trigger in the same cycle as a tick takes precedence over the tick.

Outputs:
- PLAY: `oFreq` = table frequency of the current step; `oEnable` = ~`iMute`; `oBusy` = 1; `oEffect` = effect id.
- IDLE: `oFreq` = 0, `oEnable` = 0, `oBusy` = 0, `oEffect` = 3.
- All outputs are registered, except that `iMute` gates `oEnable` combinationally.

Reset:
- Asserting `iReset` at any point, including mid-effect, immediately forces IDLE, all counters to 0, `oEnable` = 0, `oFreq` = 0, `oBusy` = 0, `oEffect` = 3 and `oDone` = 0.
- After release, the block waits for a fresh trigger.

## Timing

- Trigger sampled at edge E0 ⇒ outputs show step 0 from E0+1. Start latency is 1 cycle.
- Each step lasts exactly dur × `TICK_DIV` cycles, because the prescaler is cleared at start and step boundaries fall on ticks.
- Total effect length is Σdur × `TICK_DIV` cycles: jump 6, score 12, death 30 ticks.
- The cycle after the final tick shows IDLE outputs with `oDone` = 1 for that one cycle.
- A preempting trigger at edge E ⇒ the new step 0 is visible at E+1 and the prescaler restarts from 0.
- A trigger in the same cycle the last tick ends an effect is accepted as a fresh start. In that case `oDone` stays low and `oBusy` stays high continuously.

## Test plan

All scenarios use `TICK_DIV` = 4.

1. Jump, basic sequence: pulse `iTrig` = 3'b001 at cycle 0.
   - Cycles 1–12: `oFreq` = 880, `oEnable` = 1, `oEffect` = 0.
   - Cycles 13–24: `oFreq` = 1320.
   - Cycle 25: `oEnable` = 0, `oFreq` = 0, `oEffect` = 3, `oDone` = 1.
   - Cycle 26: `oDone` = 0.
2. Simultaneous triggers: `iTrig` = 3'b111 at cycle 0.
   - Cycles 1–24: `oFreq` = 440 and `oEffect` = 2.
   - Cycles 25–48: 330.
   - Cycles 49–72: 220.
   - Cycles 73–120: 165.
   - `oDone` = 1 at cycle 121.
3. Preemption: score at cycle 0, death at cycle 10, then jump at cycle 20.
   - At cycle 11: `oFreq` = 440, `oEffect` = 2.
   - The jump is ignored.
   - No `oDone` pulse occurs at the score's would-be end (cycle 49).
4. Equal-priority restart: jump at cycle 0, jump again at cycle 8.
   - `oFreq` = 880 through cycle 20, then 1320 for cycles 21–32.
   - `oDone` = 1 at cycle 33.
5. Mute: `iMute` = 1 during a score effect.
   - `oEnable` = 0 while `oBusy` = 1 and `oFreq` still steps 1568 → 2093.
   - `oDone` still fires at cycle 49.
6. Reset mid-effect: assert `iReset` at cycle 30 of a death effect.
   - All outputs go to their reset values within the same cycle (asynchronous).
   - After release, there is no output activity until the next `iTrig`.
